// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single FIFO port; each grant may
// keep the port for up to MAX_BURST consecutive words.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_data,
    input  logic                 fifo_full,
    output logic [N_REQ-1:0]     ack,
    output logic                 fifo_write_en,
    output logic [3:0]           fifo_write_data,
    output logic [1:0]           grant_id,
    output logic [7:0]           wr_count
);

    typedef enum logic {IDLE, BURST} state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [7:0] cnt_q, cnt_d;

    logic       winValid;
    logic [1:0] winIdx;
    logic [1:0] cand;
    logic       accept;

    // ptr resets to 3 so that requester 0 is scanned first after reset
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
            bcnt_q  <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        winValid = 1'b0;
        winIdx   = ptr_q;
        cand     = ptr_q;
        if (state_q == BURST) begin
            if (req[owner_q]) begin
                winValid = 1'b1;
                winIdx   = owner_q;
            end
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = ptr_q + 2'(k);
                if (!winValid && req[cand]) begin
                    winValid = 1'b1;
                    winIdx   = cand;
                end
            end
        end
        accept = winValid && !fifo_full && rstN;
    end

    // A full FIFO freezes everything; an owner that drops req costs one bubble
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 8'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (MAX_BURST == 1) begin
                        ptr_d = winIdx;
                    end else begin
                        state_d = BURST;
                        owner_d = winIdx;
                        bcnt_d  = 4'd1;
                    end
                end
            end
            BURST: begin
                if (!fifo_full) begin
                    if (accept && (bcnt_q + 4'd1 != 4'(MAX_BURST))) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                        bcnt_d  = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack             = '0;
        ack[winIdx]     = accept;
        fifo_write_en   = accept;
        fifo_write_data = accept ? req_data[{winIdx, 2'b00} +: 4] : 4'd0;
        grant_id        = (state_q == BURST) ? owner_q : ptr_q;
        wr_count        = cnt_q;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Parameters
REQ-001 SHALL provide N_REQ, default 4, the number of write requesters; the implementation is fixed at 4.
REQ-002 SHALL provide MAX_BURST, default 2, the maximum consecutive accepted words per grant (range 1..15).

Interface
REQ-003 SHALL have: clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have: rstN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have: req  input  4  requester i has a word pending; it is held with its data until ack[i].
REQ-006 SHALL have: req_data  input  16  requester i's word in bits [4i+3:4i].
REQ-007 SHALL have: fifo_full  input  1  the FIFO full flag.
REQ-008 SHALL have: ack  output  4  one-hot or zero; ack[i] means requester i's word is written this cycle.
REQ-009 SHALL have: fifo_write_en  output  1  the write enable to the FIFO.
REQ-010 SHALL have: fifo_write_data  output  4  the write data to the FIFO.
REQ-011 SHALL have: grant_id  output  2  the index of the current or last owner.
REQ-012 SHALL have: wr_count  output  8  the count of accepted words, wrapping.

Function
REQ-013 SHALL be a two-state FSM: IDLE (no owner) and BURST (owner o, burst counter bcnt).
REQ-014 SHALL, in IDLE, select the winner as the first asserted req scanning from (ptr+1) mod 4 upward with wrap; ptr holds the last owner.
REQ-015 SHALL, in BURST, give owner o absolute priority while req[o]=1 and bcnt<MAX_BURST.
REQ-016 SHALL accept a word combinationally in the same cycle: ack[w]=1, fifo_write_en=1, fifo_write_data=req_data[w] if and only if a winner w exists and fifo_full=0.
REQ-017 SHALL, when fifo_full=1, drive ack=0 and fifo_write_en=0 and hold FSM state, bcnt, ptr and wr_count unchanged.
REQ-018 SHALL, on an accept from IDLE, move to BURST with o=w and bcnt=1; if MAX_BURST=1, it SHALL instead stay in IDLE with ptr=w.
REQ-019 SHALL, on an accept in BURST, increment bcnt; if the new bcnt equals MAX_BURST, it SHALL go to IDLE with ptr=o and bcnt=0.
REQ-020 SHALL, in BURST with req[o]=0, accept nothing from other requesters that cycle, go to IDLE with ptr=o and bcnt=0, and re-arbitrate next cycle (one bubble cycle).
REQ-021 SHALL assert no ack and no write when all req are 0, and it SHALL leave ptr unchanged.
REQ-022 SHALL drive grant_id to o in BURST and to ptr in IDLE.
REQ-023 SHALL increment wr_count by 1 per accepted word, modulo 256, wrapping from 255 to 0.
REQ-024 SHALL never assert more than one ack bit in a cycle.
REQ-025 SHALL drive fifo_write_data to 0 whenever fifo_write_en=0.

Reset
REQ-026 SHALL, while rstN=0, asynchronously force: state IDLE, ptr=3 (requester 0 has first priority), bcnt=0, wr_count=0, grant_id=3.
REQ-027 SHALL, while rstN=0, force ack=0 and fifo_write_en=0 regardless of req.
REQ-028 SHALL, on a reset mid-burst, discard ownership; the first cycle after release arbitrates from requester 0.

Verification
REQ-029 SHALL cover: reset release with req=4'b1111, full=0, MAX_BURST=2 -> ack sequence 0,0,1,1,2,2,3,3,0 (index per cycle); wr_count=8 after 8 accepts.
REQ-030 SHALL cover: req=4'b0100, data 4'hA, full=1 for 3 cycles then 0 -> no ack for 3 cycles, then ack[2] with fifo_write_data=4'hA; wr_count increments by exactly 1.
REQ-031 SHALL cover: owner 1 in BURST drops req after 1 word while req[3]=1 -> 1 bubble cycle with no write, then ack[3].
REQ-032 SHALL cover: rstN pulsed low while owner 2 is in BURST with bcnt=1 -> ack=0 immediately; after release with req=4'b0101, ack[0] first.
REQ-033 SHALL cover: 256 single-requester accepts -> wr_count returns to 0; grant alternates IDLE/BURST per MAX_BURST.
REQ-034 SHALL cover: random req/full for 10k cycles -> ack one-hot or zero; no requester waits more than 3*MAX_BURST+3 unstalled cycles.
